mem_cycle_bridge: RTL and testbench
===================================

MEM_CYCLE_BRIDGE -- requirements
Module: mem_cycle_bridge

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, all logic on rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have ports: address in 20 (latched bus address); internal_data_bus in 8 (write data); memory_read_n, memory_write_n, io_write_n in 1 each (active-low strobes).
REQ-003 SHALL have ports: ems_enabled in 1; ems_address in 2 (EMS port base: 00=0x208, 01=0x218, 10=0x258, 11=0x268).
REQ-004 SHALL have ports: ram_address_select_n out 1; memory_access_ready out 1; data_bus_out out 8.
REQ-005 SHALL have SDRAM-side ports: req out 1; req_write out 1; req_address out 22; req_wdata out 8; ack in 1 (one-cycle pulse); rdata in 8 (valid with ack).
REQ-006 SHALL have status output timeout_err out 1, sticky until reset.

Function
REQ-007 Decode SHALL be combinational: conventional hit = address < 0xA0000, phys = {2'b00, address}.
REQ-008 EMS hit SHALL be: ems_enabled, address[19:16]==0xD, page n=address[15:14] enabled; phys = 0x100000 + {map[n][6:0], address[13:0]}, 22-bit addition with no wrap.
REQ-009 ram_address_select_n SHALL be ~(conventional hit | EMS hit), independent of strobes.
REQ-010 An I/O write SHALL update page register n on the rising clock edge where io_write_n is low and address[15:0]==base+n, n=0..3: enable<=data[7], map<=data[6:0].
REQ-011 A page-register write SHALL NOT start an SDRAM request.
REQ-012 The FSM SHALL have states IDLE, REQ, DONE.
REQ-013 IDLE->REQ SHALL occur on a clock edge where exactly one memory strobe is low and the address hits, and that strobe was high on the previous edge (falling-edge detect on registered copy).
REQ-014 On IDLE->REQ the block SHALL register req_address, req_write (1 for write), and req_wdata, and SHALL assert req.
REQ-015 When both memory strobes are low, the block SHALL start no cycle and SHALL hold memory_access_ready high.
REQ-016 In REQ, req SHALL stay high until the edge where ack=1; on that edge, a read SHALL latch rdata into data_bus_out, and the FSM SHALL go to DONE.
REQ-017 A strobe deasserting while in REQ SHALL NOT abort the request; after ack, the FSM SHALL go directly to IDLE if the strobe is already high.
REQ-018 DONE SHALL hold until the active strobe returns high, then go to IDLE; no new cycle SHALL start in the same edge.
REQ-019 memory_access_ready SHALL be combinational: 0 when (hit & exactly one memory strobe low & state != DONE), else 1. Ready therefore drops in the same cycle the strobe falls.
REQ-020 An 8-bit counter SHALL clear on entry to REQ and increment each cycle in REQ.
REQ-021 When the counter reaches 255 without ack, the FSM SHALL go to DONE, drop req, load data_bus_out=0xFF, and set timeout_err.
REQ-022 An ack arriving in the same edge as count 255 SHALL win, with no error.
REQ-023 An ack received outside REQ SHALL be ignored.
REQ-024 data_bus_out SHALL hold the last read value until the next read completes.

Reset
REQ-025 On reset, the block SHALL set: FSM=IDLE, req=0, req_write=0, req_address=0, req_wdata=0, data_bus_out=0xFF, timeout_err=0, counter=0.
REQ-026 On reset, all four page enables SHALL be 0 and all maps 0; the registered strobe copies SHALL be 1.
REQ-027 Reset asserted mid-REQ SHALL drop req immediately (asynchronously); a late ack after reset release SHALL be ignored.

Verification
REQ-028 Read at 0x12345, ack with rdata=0x5A after 3 cycles -> req_address=0x012345, req_write=0, ready low until ack edge, data_bus_out=0x5A.
REQ-029 ems_address=01, OUT 0x219 with 0x85; write 0xC3 to 0xD4010 -> req_address=0x114010, req_write=1, req_wdata=0xC3.
REQ-030 EMS page 2 disabled, read 0xD8000 -> ram_address_select_n=1, no req, ready stays high.
REQ-031 Read at 0x00100, never ack -> req drops after 255 REQ cycles, data_bus_out=0xFF, timeout_err=1, ready high.
REQ-032 Both strobes low at 0x00000 -> no req, ready=1. Separately, reset pulse during REQ -> req=0 at once, FSM IDLE.
REQ-033 Strobe released before ack -> req held until ack, then IDLE without passing through DONE.

Source files
------------

// File: rtl/mem_cycle_bridge_if.sv
// mem_cycle_bridge_if: CPU-side bus, EMS config and SDRAM request signals of the bridge.
interface mem_cycle_bridge_if;
  logic [19:0] address;
  logic [7:0]  internal_data_bus;
  logic        memory_read_n;
  logic        memory_write_n;
  logic        io_write_n;
  logic        ems_enabled;
  logic [1:0]  ems_address;
  logic        ram_address_select_n;
  logic        memory_access_ready;
  logic [7:0]  data_bus_out;
  logic        req;
  logic        req_write;
  logic [21:0] req_address;
  logic [7:0]  req_wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        timeout_err;
  modport slave (
    input  address, internal_data_bus, memory_read_n, memory_write_n, io_write_n,
    input  ems_enabled, ems_address, ack, rdata,
    output ram_address_select_n, memory_access_ready, data_bus_out,
    output req, req_write, req_address, req_wdata, timeout_err
  );
  modport master (
    output address, internal_data_bus, memory_read_n, memory_write_n, io_write_n,
    output ems_enabled, ems_address, ack, rdata,
    input  ram_address_select_n, memory_access_ready, data_bus_out,
    input  req, req_write, req_address, req_wdata, timeout_err
  );
endinterface

// File: rtl/mem_cycle_bridge.sv
// mem_cycle_bridge: turns CPU memory strobes into single SDRAM requests, with EMS page
// mapping in the 0xD0000 window and a 255-cycle ack timeout.
module mem_cycle_bridge (
  input logic clock,
  input logic reset,
  mem_cycle_bridge_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [3:0]      page_en;
  logic [3:0][6:0] page_map;
  logic            rd_q, wr_q;
  logic [7:0]      count;
  logic [1:0]      page;
  logic [15:0]     base;
  logic [21:0]     phys;
  logic            conv_hit, ems_hit, hit, one_low, fall, start, active_high, timeout;
  always_comb begin
    page = bus.address[15:14];
    base = bus.ems_address == 2'd0 ? 16'h0208 :
           bus.ems_address == 2'd1 ? 16'h0218 :
           bus.ems_address == 2'd2 ? 16'h0258 : 16'h0268;
    conv_hit = bus.address < 20'hA0000;
    ems_hit = bus.ems_enabled & (bus.address[19:16] == 4'hD) & page_en[page];
    hit = conv_hit | ems_hit;
    phys = conv_hit ? {2'b00, bus.address} :
           22'h100000 + {1'b0, page_map[page], bus.address[13:0]};
    one_low = bus.memory_read_n ^ bus.memory_write_n;
    fall = (~bus.memory_read_n & rd_q) | (~bus.memory_write_n & wr_q);
    start = (state == IDLE) & hit & one_low & fall;
    active_high = bus.req_write ? bus.memory_write_n : bus.memory_read_n;
    // the edge that would take the counter to 255 is the timeout edge unless ack arrives
    timeout = ~bus.ack & (count == 8'd254);
    state_nx = state == IDLE ? (start ? REQ : IDLE) :
               state == REQ  ? (bus.ack ? (active_high ? IDLE : DONE) : (timeout ? DONE : REQ)) :
               (active_high ? IDLE : DONE);
    bus.ram_address_select_n = ~hit;
    bus.memory_access_ready = ~(hit & one_low & (state != DONE));
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      page_en <= '0;
      page_map <= '0;
    end else if (~bus.io_write_n) begin
      for (int i = 0; i < 4; i++)
        if (bus.address[15:0] == base + 16'(i)) begin
          page_en[i] <= bus.internal_data_bus[7];
          page_map[i] <= bus.internal_data_bus[6:0];
        end
    end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      rd_q <= 1'b1;
      wr_q <= 1'b1;
      count <= '0;
      bus.req <= 1'b0;
      bus.req_write <= 1'b0;
      bus.req_address <= '0;
      bus.req_wdata <= '0;
      bus.data_bus_out <= 8'hFF;
      bus.timeout_err <= 1'b0;
    end else begin
      rd_q <= bus.memory_read_n;
      wr_q <= bus.memory_write_n;
      if (start) begin
        bus.req <= 1'b1;
        bus.req_write <= ~bus.memory_write_n;
        bus.req_address <= phys;
        bus.req_wdata <= bus.internal_data_bus;
        count <= '0;
      end
      if (state == REQ) begin
        count <= count + 8'd1;
        if (bus.ack) begin
          bus.req <= 1'b0;
          if (~bus.req_write) bus.data_bus_out <= bus.rdata;
        end else if (timeout) begin
          bus.req <= 1'b0;
          bus.data_bus_out <= 8'hFF;
          bus.timeout_err <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_mem_cycle_bridge.sv
// tb_mem_cycle_bridge: decode vector table plus directed multi-cycle sequences.
module tb_mem_cycle_bridge;
  typedef struct {
    logic [19:0] addr;
    logic        rd_n;
    logic        wr_n;
    logic        sel_n;
    logic        ready;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  vec_t vecs[10];
  mem_cycle_bridge_if bus();
  mem_cycle_bridge dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic io_out(input logic [19:0] a, input logic [7:0] d);
    @(negedge clock);
    bus.address = a;
    bus.internal_data_bus = d;
    bus.io_write_n = 1'b0;
    @(posedge clock);
    #1 bus.io_write_n = 1'b1;
  endtask
  task automatic ack_pulse(input logic [7:0] d);
    @(negedge clock);
    bus.ack = 1'b1;
    bus.rdata = d;
    @(posedge clock);
    #1 bus.ack = 1'b0;
  endtask
  // ready with a hit and one strobe low is 0 only outside DONE; strobe is released before the edge
  task automatic probe_idle(input string name);
    @(negedge clock);
    bus.address = 20'h00000;
    bus.memory_read_n = 1'b0;
    #1 check(name, bus.memory_access_ready, 0);
    #1 bus.memory_read_n = 1'b1;
  endtask
  task automatic start_cycle(input logic [19:0] a, input logic wr, input logic [7:0] d);
    @(negedge clock);
    bus.address = a;
    bus.internal_data_bus = d;
    if (wr) bus.memory_write_n = 1'b0;
    else bus.memory_read_n = 1'b0;
    @(posedge clock);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end
  initial begin
    int n;
    vecs[0] = '{20'h00000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{20'h12345, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{20'h9FFFF, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{20'hA0000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{20'hD4010, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{20'hD8000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{20'hDC000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{20'h00000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{20'hFFFFF, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{20'hC4010, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.address = '0;
    bus.internal_data_bus = '0;
    bus.memory_read_n = 1'b1;
    bus.memory_write_n = 1'b1;
    bus.io_write_n = 1'b1;
    bus.ems_enabled = 1'b1;
    bus.ems_address = 2'b01;
    bus.ack = 1'b0;
    bus.rdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", bus.req, 0);
    check("rst_req_write", bus.req_write, 0);
    check("rst_req_address", bus.req_address, 0);
    check("rst_req_wdata", bus.req_wdata, 0);
    check("rst_data_bus_out", bus.data_bus_out, 8'hFF);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_ready", bus.memory_access_ready, 1);
    @(negedge clock) reset = 1'b0;
    io_out(20'h00219, 8'h85);
    check("io_no_req", bus.req, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      bus.address = vecs[i].addr;
      bus.memory_read_n = vecs[i].rd_n;
      bus.memory_write_n = vecs[i].wr_n;
      #1;
      check($sformatf("vec%0d_sel_n", i), bus.ram_address_select_n, vecs[i].sel_n);
      check($sformatf("vec%0d_ready", i), bus.memory_access_ready, vecs[i].ready);
      #1;
      bus.memory_read_n = 1'b1;
      bus.memory_write_n = 1'b1;
    end
    @(posedge clock);
    #1 check("vec_no_req", bus.req, 0);
    start_cycle(20'h12345, 1'b0, 8'h00);
    check("rd_req", bus.req, 1);
    check("rd_req_address", bus.req_address, 22'h012345);
    check("rd_req_write", bus.req_write, 0);
    repeat (2) begin
      @(posedge clock);
      #1 check("rd_wait_ready", bus.memory_access_ready, 0);
      check("rd_wait_req", bus.req, 1);
    end
    ack_pulse(8'h5A);
    check("rd_ack_req", bus.req, 0);
    check("rd_data", bus.data_bus_out, 8'h5A);
    check("rd_done_ready", bus.memory_access_ready, 1);
    @(negedge clock) bus.memory_read_n = 1'b1;
    @(posedge clock);
    ack_pulse(8'h11);
    check("stray_ack_req", bus.req, 0);
    check("stray_ack_data", bus.data_bus_out, 8'h5A);
    start_cycle(20'hD4010, 1'b1, 8'hC3);
    check("ems_req", bus.req, 1);
    check("ems_req_address", bus.req_address, 22'h114010);
    check("ems_req_write", bus.req_write, 1);
    check("ems_req_wdata", bus.req_wdata, 8'hC3);
    @(negedge clock) bus.memory_write_n = 1'b1;
    repeat (2) @(posedge clock);
    #1 check("early_release_req", bus.req, 1);
    ack_pulse(8'h22);
    check("wr_ack_req", bus.req, 0);
    check("wr_keeps_data", bus.data_bus_out, 8'h5A);
    probe_idle("early_release_idle");
    @(negedge clock);
    bus.address = 20'h00000;
    bus.memory_read_n = 1'b0;
    bus.memory_write_n = 1'b0;
    #1 check("both_low_ready", bus.memory_access_ready, 1);
    @(posedge clock);
    #1 check("both_low_req", bus.req, 0);
    @(negedge clock);
    bus.memory_read_n = 1'b1;
    bus.memory_write_n = 1'b1;
    start_cycle(20'h00100, 1'b0, 8'h00);
    check("to_req", bus.req, 1);
    n = 0;
    while (bus.req && n < 300) begin
      @(posedge clock);
      #1 n++;
    end
    check("to_cycles", n, 255);
    check("to_data", bus.data_bus_out, 8'hFF);
    check("to_err", bus.timeout_err, 1);
    check("to_ready", bus.memory_access_ready, 1);
    @(negedge clock) bus.memory_read_n = 1'b1;
    @(posedge clock);
    #1 check("to_err_sticky", bus.timeout_err, 1);
    start_cycle(20'h00300, 1'b0, 8'h00);
    check("mid_rst_req_before", bus.req, 1);
    #2 reset = 1'b1;
    #1 check("mid_rst_req", bus.req, 0);
    check("mid_rst_err", bus.timeout_err, 0);
    bus.memory_read_n = 1'b1;
    @(negedge clock) reset = 1'b0;
    ack_pulse(8'h77);
    check("late_ack_req", bus.req, 0);
    check("late_ack_data", bus.data_bus_out, 8'hFF);
    probe_idle("mid_rst_idle");
    @(negedge clock) bus.address = 20'hD4010;
    #1 check("rst_pages_cleared", bus.ram_address_select_n, 1);
    start_cycle(20'h00200, 1'b0, 8'h00);
    repeat (254) @(posedge clock);
    #1 check("edge_req_held", bus.req, 1);
    ack_pulse(8'h3C);
    check("edge_ack_req", bus.req, 0);
    check("edge_ack_data", bus.data_bus_out, 8'h3C);
    check("edge_ack_no_err", bus.timeout_err, 0);
    @(negedge clock) bus.memory_read_n = 1'b1;
    @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
